// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive path.
// Holds the receiver state encoding, the default oversample ratio and the parity helper.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam int DEFAULT_OVERSAMPLE = 16;
  localparam int MAX_DATA_WIDTH     = 8;

  // Expected parity bit for a word: even parity when odd=0, odd parity when odd=1.
  function automatic logic parity_bit(input logic [MAX_DATA_WIDTH-1:0] data,
                                      input logic                      odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_tick_gen.sv
// Oversample tick generator: one-cycle tick every max(div_i,1) clocks while enabled.
// clr_i restarts the count so the first tick lands a full period after a start edge.
module uart_baud_tick_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_i,
  input  logic                 clr_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] last_s;
  logic [DIV_WIDTH-1:0] cnt_d;
  logic [DIV_WIDTH-1:0] cnt_q;

  // Terminal count (div of zero behaves as one) and next count value.
  always_comb begin
    cnt_d = cnt_q;
    if (div_i == {DIV_WIDTH{1'b0}}) begin
      last_s = {DIV_WIDTH{1'b0}};
    end else begin
      last_s = div_i - {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    end
    if (clr_i) begin
      cnt_d = {DIV_WIDTH{1'b0}};
    end else if (en_i) begin
      if (cnt_q >= last_s) begin
        cnt_d = {DIV_WIDTH{1'b0}};
      end else begin
        cnt_d = cnt_q + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_d = {DIV_WIDTH{1'b0}};
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= {DIV_WIDTH{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && !clr_i && (cnt_q == last_s);

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receiver: synchronizes the line, oversamples each bit at its centre and rebuilds
// start/data/parity/stop frames, delivering words with flags over a valid/ready port.
module uart_rx_deserializer
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIV_WIDTH-1:0]  baud_div,
  input  logic                  parity_en,
  input  logic                  parity_odd,
  input  logic                  rx_in,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun_err,
  output logic                  busy
);

  localparam int SMP_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [SMP_W-1:0] HALF_LAST = SMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SMP_W-1:0] FULL_LAST = SMP_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

  logic                  sync1_q;
  logic                  sync2_q;
  logic                  rx_s;
  logic                  tick_s;
  logic                  tick_en_s;
  logic                  start_det_s;

  rx_state_e             state_q;
  logic                  armed_q;
  logic [SMP_W-1:0]      smp_cnt_q;
  logic [IDX_W-1:0]      bit_idx_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DIV_WIDTH-1:0]  div_q;
  logic                  par_en_q;
  logic                  par_odd_q;
  logic                  par_err_q;
  logic                  busy_q;
  logic                  load_q;
  logic [DATA_WIDTH-1:0] ld_data_q;
  logic                  ld_perr_q;
  logic                  ld_ferr_q;

  logic [DATA_WIDTH-1:0] rx_data_q;
  logic                  rx_valid_q;
  logic                  parity_err_q;
  logic                  frame_err_q;
  logic                  overrun_q;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_in;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s        = sync2_q;
  assign tick_en_s   = (state_q != IDLE);
  assign start_det_s = (state_q == IDLE) && armed_q && !rx_s;

  uart_baud_tick_gen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (tick_en_s),
    .clr_i  (start_det_s),
    .div_i  (div_q),
    .tick_o (tick_s)
  );

  // Frame FSM: start qualification, mid-bit sampling, parity/stop checks, load request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      armed_q   <= 1'b0;
      smp_cnt_q <= {SMP_W{1'b0}};
      bit_idx_q <= {IDX_W{1'b0}};
      shift_q   <= {DATA_WIDTH{1'b0}};
      div_q     <= {DIV_WIDTH{1'b0}};
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      par_err_q <= 1'b0;
      busy_q    <= 1'b0;
      load_q    <= 1'b0;
      ld_data_q <= {DATA_WIDTH{1'b0}};
      ld_perr_q <= 1'b0;
      ld_ferr_q <= 1'b0;
    end else begin
      load_q <= 1'b0;
      case (state_q)
        IDLE: begin
          armed_q <= rx_s;
          if (start_det_s) begin
            state_q   <= START;
            busy_q    <= 1'b1;
            smp_cnt_q <= {SMP_W{1'b0}};
            bit_idx_q <= {IDX_W{1'b0}};
            div_q     <= baud_div;
            par_en_q  <= parity_en;
            par_odd_q <= parity_odd;
            par_err_q <= 1'b0;
          end
        end
        START: begin
          if (tick_s) begin
            if (smp_cnt_q == HALF_LAST) begin
              smp_cnt_q <= {SMP_W{1'b0}};
              if (rx_s) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                armed_q <= 1'b1;
              end else begin
                state_q   <= DATA;
                bit_idx_q <= {IDX_W{1'b0}};
              end
            end else begin
              smp_cnt_q <= smp_cnt_q + SMP_W'(1);
            end
          end
        end
        DATA: begin
          if (tick_s) begin
            if (smp_cnt_q == FULL_LAST) begin
              smp_cnt_q <= {SMP_W{1'b0}};
              shift_q   <= {rx_s, shift_q[DATA_WIDTH-1:1]};
              if (bit_idx_q == IDX_LAST) begin
                state_q <= par_en_q ? PARITY : STOP;
              end else begin
                bit_idx_q <= bit_idx_q + IDX_W'(1);
              end
            end else begin
              smp_cnt_q <= smp_cnt_q + SMP_W'(1);
            end
          end
        end
        PARITY: begin
          if (tick_s) begin
            if (smp_cnt_q == FULL_LAST) begin
              smp_cnt_q <= {SMP_W{1'b0}};
              par_err_q <= (rx_s != parity_bit(MAX_DATA_WIDTH'(shift_q), par_odd_q));
              state_q   <= STOP;
            end else begin
              smp_cnt_q <= smp_cnt_q + SMP_W'(1);
            end
          end
        end
        STOP: begin
          if (tick_s) begin
            if (smp_cnt_q == FULL_LAST) begin
              // A low stop leaves IDLE disarmed until the line is seen high again.
              smp_cnt_q <= {SMP_W{1'b0}};
              load_q    <= 1'b1;
              ld_data_q <= shift_q;
              ld_perr_q <= par_err_q;
              ld_ferr_q <= !rx_s;
              state_q   <= IDLE;
              busy_q    <= 1'b0;
              armed_q   <= 1'b0;
            end else begin
              smp_cnt_q <= smp_cnt_q + SMP_W'(1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          armed_q <= 1'b0;
        end
      endcase
    end
  end

  // Output holding register: load, overrun drop, and valid/ready handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data_q    <= {DATA_WIDTH{1'b0}};
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (load_q) begin
        if (rx_valid_q && !rx_ready) begin
          overrun_q <= 1'b1;
        end else begin
          rx_data_q    <= ld_data_q;
          parity_err_q <= ld_perr_q;
          frame_err_q  <= ld_ferr_q;
          rx_valid_q   <= 1'b1;
        end
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end else begin
        rx_valid_q <= rx_valid_q;
      end
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer: directed frames plus randomized frames
// compared against a word-level model of what a UART receiver must deliver.
module tb_uart_rx_deserializer;

  localparam int OS = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] baud_div;
  logic        parity_en;
  logic        parity_odd;
  logic        rx_in;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        parity_err;
  logic        frame_err;
  logic        overrun_err;
  logic        busy;

  always #5 clk = ~clk;

  uart_rx_deserializer #(
    .DATA_WIDTH (8),
    .OVERSAMPLE (OS),
    .DIV_WIDTH  (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .baud_div    (baud_div),
    .parity_en   (parity_en),
    .parity_odd  (parity_odd),
    .rx_in       (rx_in),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .busy        (busy)
  );

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         at;
  } word_t;

  word_t got_q[$];
  word_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  int    ovr_cnt  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted word and every overrun cycle.
  always @(negedge clk) begin
    if (rst_n && rx_valid && rx_ready)
      got_q.push_back('{d: rx_data, pe: parity_err, fe: frame_err, at: cyc});
    if (overrun_err) ovr_cnt <= ovr_cnt + 1;
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic good_pbit(input logic [7:0] d, input logic odd);
    return (($countones(d) % 2) == 1) ^ odd;
  endfunction

  function automatic logic model_perr(input logic [7:0] d, input logic pen, input logic odd,
                                      input logic pbit);
    return pen && ((($countones(d) + int'(pbit)) % 2) != int'(odd));
  endfunction

  task automatic expect_word(input logic [7:0] d, input logic pe, input logic fe);
    exp_q.push_back('{d: d, pe: pe, fe: fe, at: 0});
  endtask

  task automatic compare_words(input string tag);
    int n;
    check_value({tag, "_nwords"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_value($sformatf("%s_data%0d", tag, i), got_q[i].d, exp_q[i].d);
      check_value($sformatf("%s_perr%0d", tag, i), got_q[i].pe, exp_q[i].pe);
      check_value($sformatf("%s_ferr%0d", tag, i), got_q[i].fe, exp_q[i].fe);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame; the line is left at the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                            input logic stop, input int bclk, output int t0);
    t0 = cyc;
    rx_in = 1'b0;
    repeat (bclk) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      repeat (bclk) @(posedge clk);
      #1;
    end
    if (pen) begin
      rx_in = pbit;
      repeat (bclk) @(posedge clk);
      #1;
    end
    rx_in = stop;
    repeat (bclk) @(posedge clk);
    #1;
  endtask

  task automatic wait_busy_fall(output bit ok);
    bit seen;
    seen = 1'b0;
    ok   = 1'b0;
    for (int k = 0; k < 4000 && !ok; k++) begin
      @(posedge clk);
      #1;
      if (busy) seen = 1'b1;
      else if (seen) ok = 1'b1;
    end
  endtask

  int         t0;
  int         ovr_base;
  int         dv;
  int         bclk;
  bit         ok;
  logic [7:0] rd;
  logic       rpen, rodd, rpbit, rstop;

  initial begin
    rst_n      = 1'b0;
    rx_in      = 1'b1;
    baud_div   = 16'd4;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    rx_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_value("rst_valid", rx_valid, 1'b0);
    check_value("rst_data", rx_data, 8'h00);
    check_value("rst_busy", busy, 1'b0);
    check_value("rst_flags", {parity_err, frame_err, overrun_err}, 3'b000);
    rst_n = 1'b1;
    idle(20);

    // Plain 0xA5, no parity, with latency window around 611 clocks.
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 64, t0);
    idle(32);
    expect_word(8'hA5, 1'b0, 1'b0);
    if (got_q.size() > 0)
      check_value("a5_latency_ok", (got_q[0].at - t0 >= 607) && (got_q[0].at - t0 <= 616), 1'b1);
    compare_words("a5");

    // 0x3C even parity: wrong parity bit then correct one.
    parity_en = 1'b1;
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 64, t0);
    idle(32);
    expect_word(8'h3C, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 64, t0);
    idle(32);
    expect_word(8'h3C, 1'b0, 1'b0);
    compare_words("par3c");
    parity_en = 1'b0;

    // 20-clock glitch: false start, nothing delivered.
    rx_in = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_value("glitch_busy_hi", busy, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    idle(160);
    check_value("glitch_busy_lo", busy, 1'b0);
    compare_words("glitch");

    // Break: low stop then line held low; a real frame only after the line returns high.
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 64, t0);
    repeat (96) @(posedge clk);
    #1;
    check_value("break_busy", busy, 1'b0);
    repeat (96) @(posedge clk);
    #1;
    idle(64);
    send_frame(8'h96, 1'b0, 1'b0, 1'b1, 64, t0);
    idle(32);
    expect_word(8'h55, 1'b0, 1'b1);
    expect_word(8'h96, 1'b0, 1'b0);
    compare_words("break");

    // Overrun: consumer stalled, second word dropped.
    rx_ready = 1'b0;
    ovr_base = ovr_cnt;
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 64, t0);
    idle(16);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1, 64, t0);
    idle(32);
    check_value("ovr_held_valid", rx_valid, 1'b1);
    check_value("ovr_held_data", rx_data, 8'h11);
    check_value("ovr_pulses", ovr_cnt - ovr_base, 1);
    rx_ready = 1'b1;
    idle(8);
    expect_word(8'h11, 1'b0, 1'b0);
    compare_words("ovr");

    // Acceptance in the load cycle: new word replaces old, no overrun.
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 64, t0);
    idle(16);
    ovr_base = ovr_cnt;
    fork
      begin
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 64, t0);
        idle(32);
      end
      begin
        wait_busy_fall(ok);
        rx_ready = 1'b1;
      end
    join
    check_value("repl_window", ok, 1'b1);
    check_value("repl_no_ovr", ovr_cnt - ovr_base, 0);
    expect_word(8'h11, 1'b0, 1'b0);
    expect_word(8'h22, 1'b0, 1'b0);
    compare_words("repl");

    // Reset mid-DATA of 0xFF while a word is held; only the following 0x0F arrives.
    rx_ready = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 64, t0);
    idle(16);
    fork
      begin
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 64, t0);
        idle(32);
      end
      begin
        repeat (64 * 3 + 20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_value("mid_rst_valid", rx_valid, 1'b0);
        check_value("mid_rst_data", rx_data, 8'h00);
        check_value("mid_rst_busy", busy, 1'b0);
        check_value("mid_rst_flags", {parity_err, frame_err, overrun_err}, 3'b000);
        rst_n = 1'b1;
      end
    join
    rx_ready = 1'b1;
    send_frame(8'h0F, 1'b0, 1'b0, 1'b1, 64, t0);
    idle(32);
    expect_word(8'h0F, 1'b0, 1'b0);
    compare_words("mid_rst");

    // Randomized frames: random divider, parity mode, corrupted parity/stop, mid-frame config churn.
    for (int f = 0; f < 10; f++) begin
      rd         = 8'($urandom);
      rpen       = 1'($urandom);
      rodd       = 1'($urandom);
      rpbit      = good_pbit(rd, rodd) ^ ($urandom_range(0, 3) == 0);
      rstop      = ($urandom_range(0, 3) != 0);
      dv         = $urandom_range(0, 5);
      bclk       = OS * ((dv == 0) ? 1 : dv);
      baud_div   = 16'(dv);
      parity_en  = rpen;
      parity_odd = rodd;
      fork
        send_frame(rd, rpen, rpbit, rstop, bclk, t0);
        begin
          repeat (10) @(posedge clk);
          #1;
          baud_div   = 16'($urandom_range(1, 9));
          parity_en  = ~parity_en;
          parity_odd = ~parity_odd;
        end
      join
      idle($urandom_range(8, 60));
      expect_word(rd, model_perr(rd, rpen, rodd, rpbit), !rstop);
      compare_words($sformatf("rnd%0d", f));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
